adder_share_arb: RTL and testbench

- Shares one combinational 16-bit add/sub datapath (adder_16bit_b) between two requesters.
- Each requester uses a valid/ready handshake; requesters are served round-robin.
- One result register holds the result, tagged with the requester ID, under consumer backpressure.
- Sits between the ALU-issue logic and the single adder instance; also keeps a wrap-around count of completed operations.

---
 rtl/adder_share_arb_pkg.sv | 26 ++
 rtl/adder_16bit_b.sv | 32 +++
 rtl/adder_share_arb.sv | 153 +++++++++++++++
 tb/tb_adder_share_arb.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_share_arb_pkg.sv
// Shared types and constants for the two-requester shared adder front end.
// Imported by the arbiter top and the ripple adder.
package adder_share_arb_pkg;

  localparam int W_DEF = 16;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam logic CTRL_ADD = 1'b0;
  localparam logic CTRL_SUB = 1'b1;

  // One-bit state: the encoding is exactly res_valid.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } res_state_e;

  typedef struct packed {
    logic             id;
    logic             ovf;
    logic             cout;
    logic [W_DEF-1:0] sum;
  } res_rec_t;

endpackage

// File: rtl/adder_16bit_b.sv
// Combinational 16-bit ripple-carry add/subtract.
// Subtraction is A + ~B + 1; O flags signed two's-complement overflow.
module adder_16bit_b
  import adder_share_arb_pkg::*;
(
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Add_ctrl,
  output logic [15:0] SUM,
  output logic        C_out,
  output logic        O
);

  logic [15:0] b_x;
  logic [16:0] carry;

  assign b_x      = B ^ {16{Add_ctrl == CTRL_SUB}};
  assign carry[0] = (Add_ctrl == CTRL_SUB);

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_fa
      assign SUM[gi]       = A[gi] ^ b_x[gi] ^ carry[gi];
      assign carry[gi + 1] = (A[gi] & b_x[gi]) | (carry[gi] & (A[gi] ^ b_x[gi]));
    end
  endgenerate

  assign C_out = carry[16];
  // Overflow when the carry into the sign bit differs from the carry out of it.
  assign O     = carry[16] ^ carry[15];

endmodule

// File: rtl/adder_share_arb.sv
// Round-robin arbiter sharing one adder_16bit_b between two valid/ready requesters,
// with a single backpressured result register and a wrapping consumed-op counter.
module adder_share_arb
  import adder_share_arb_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [W-1:0]     req0_a,
  input  logic [W-1:0]     req0_b,
  input  logic             req0_ctrl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [W-1:0]     req1_a,
  input  logic [W-1:0]     req1_b,
  input  logic             req1_ctrl,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic [W-1:0]     res_sum,
  output logic             res_cout,
  output logic             res_ovf,
  output logic [CNT_W-1:0] op_count
);

  res_state_e       state_q, state_d;
  res_rec_t         res_q, res_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic             slot_free;
  logic             grant_valid;
  logic             grant_id;
  logic             accept;
  logic             consume;

  logic [W-1:0]     add_a;
  logic [W-1:0]     add_b;
  logic             add_ctrl;
  logic [W-1:0]     add_sum;
  logic             add_cout;
  logic             add_ovf;

  assign res_valid = (state_q == ST_FULL);
  assign slot_free = !res_valid || res_ready;
  assign accept    = grant_valid;
  assign consume   = res_valid && res_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: any accept fills the slot; a drain without refill empties it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (res_ready && !accept) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Grant and adder operand mux. Readies are held low while reset is asserted.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = REQ0;
    if (rst_n && slot_free) begin
      if (req0_valid && req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = ~last_grant_q;
      end else if (req0_valid) begin
        grant_valid = 1'b1;
        grant_id    = REQ0;
      end else if (req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = REQ1;
      end
    end

    req0_ready = grant_valid && (grant_id == REQ0);
    req1_ready = grant_valid && (grant_id == REQ1);

    add_a    = '0;
    add_b    = '0;
    add_ctrl = CTRL_ADD;
    if (req0_ready) begin
      add_a    = req0_a;
      add_b    = req0_b;
      add_ctrl = req0_ctrl;
    end else if (req1_ready) begin
      add_a    = req1_a;
      add_b    = req1_b;
      add_ctrl = req1_ctrl;
    end
  end

  adder_16bit_b u_adder (
    .A        (add_a),
    .B        (add_b),
    .Add_ctrl (add_ctrl),
    .SUM      (add_sum),
    .C_out    (add_cout),
    .O        (add_ovf)
  );

  // Data fields load only on accept so a drain leaves the last result visible.
  always_comb begin
    res_d        = res_q;
    last_grant_d = last_grant_q;
    op_count_d   = op_count_q;
    if (accept) begin
      res_d.id     = grant_id;
      res_d.ovf    = add_ovf;
      res_d.cout   = add_cout;
      res_d.sum    = add_sum;
      last_grant_d = grant_id;
    end
    if (consume) begin
      op_count_d = op_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q        <= '0;
      last_grant_q <= REQ1;
      op_count_q   <= '0;
    end else begin
      res_q        <= res_d;
      last_grant_q <= last_grant_d;
      op_count_q   <= op_count_d;
    end
  end

  // Output decode.
  always_comb begin
    res_id   = res_q.id;
    res_sum  = res_q.sum;
    res_cout = res_q.cout;
    res_ovf  = res_q.ovf;
    op_count = op_count_q;
  end

endmodule

// File: tb/tb_adder_share_arb.sv
// Directed bench for adder_share_arb: table of per-cycle vectors plus
// hand sequences for async reset mid-hold and op_count wrap (CNT_W=4).
module tb_adder_share_arb;

  localparam int W     = 16;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             req0_valid, req0_ready, req0_ctrl;
  logic [W-1:0]     req0_a, req0_b;
  logic             req1_valid, req1_ready, req1_ctrl;
  logic [W-1:0]     req1_a, req1_b;
  logic             res_valid, res_ready, res_id, res_cout, res_ovf;
  logic [W-1:0]     res_sum;
  logic [CNT_W-1:0] op_count;

  int tests;
  int failed;

  adder_share_arb #(.W(W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ctrl  (req0_ctrl),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ctrl  (req1_ctrl),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_id     (res_id),
    .res_sum    (res_sum),
    .res_cout   (res_cout),
    .res_ovf    (res_ovf),
    .op_count   (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v0;
    logic [15:0] a0;
    logic [15:0] b0;
    logic        c0;
    logic        v1;
    logic [15:0] a1;
    logic [15:0] b1;
    logic        c1;
    logic        rr;
    logic        er0;
    logic        er1;
    logic        ev;
    logic        eid;
    logic [15:0] esum;
    logic        ec;
    logic        eo;
    logic [3:0]  ecnt;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic v0, input logic [15:0] a0, input logic [15:0] b0, input logic c0,
    input logic v1, input logic [15:0] a1, input logic [15:0] b1, input logic c1,
    input logic rr, input logic er0, input logic er1,
    input logic ev, input logic eid, input logic [15:0] esum,
    input logic ec, input logic eo, input logic [3:0] ecnt);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.b0 = b0; v.c0 = c0;
    v.v1 = v1; v.a1 = a1; v.b1 = b1; v.c1 = c1;
    v.rr = rr; v.er0 = er0; v.er1 = er1;
    v.ev = ev; v.eid = eid; v.esum = esum; v.ec = ec; v.eo = eo; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [15:0] a0, input logic [15:0] b0, input logic c0,
                       input logic v1, input logic [15:0] a1, input logic [15:0] b1, input logic c1,
                       input logic rr);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_ctrl = c0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_ctrl = c1;
    res_ready  = rr;
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst_n  = 1'b0;
    drive(0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0);

    // Vectors: inputs | ready0 ready1 | after edge: valid id sum cout ovf op_count
    vecs[0]  = mk(1,16'h7FFF,16'h0001,0, 0,16'h0000,16'h0000,0, 1, 1,0, 1,0,16'h8000,0,1, 4'd0);
    vecs[1]  = mk(0,16'h0000,16'h0000,0, 0,16'h0000,16'h0000,0, 1, 0,0, 0,0,16'h8000,0,1, 4'd1);
    vecs[2]  = mk(1,16'h0000,16'h0001,1, 1,16'hFFFF,16'h0001,0, 1, 0,1, 1,1,16'h0000,1,0, 4'd1);
    vecs[3]  = mk(1,16'h0000,16'h0001,1, 1,16'hFFFF,16'h0001,0, 1, 1,0, 1,0,16'hFFFF,0,0, 4'd2);
    vecs[4]  = mk(1,16'h0000,16'h0001,1, 1,16'hFFFF,16'h0001,0, 1, 0,1, 1,1,16'h0000,1,0, 4'd3);
    vecs[5]  = mk(1,16'h0000,16'h0001,1, 1,16'hFFFF,16'h0001,0, 1, 1,0, 1,0,16'hFFFF,0,0, 4'd4);
    vecs[6]  = mk(1,16'h0000,16'h0001,1, 1,16'hFFFF,16'h0001,0, 0, 0,0, 1,0,16'hFFFF,0,0, 4'd4);
    vecs[7]  = mk(1,16'h0000,16'h0001,1, 1,16'hFFFF,16'h0001,0, 0, 0,0, 1,0,16'hFFFF,0,0, 4'd4);
    vecs[8]  = mk(1,16'h0000,16'h0001,1, 1,16'hFFFF,16'h0001,0, 0, 0,0, 1,0,16'hFFFF,0,0, 4'd4);
    vecs[9]  = mk(1,16'h0000,16'h0001,1, 1,16'hFFFF,16'h0001,0, 0, 0,0, 1,0,16'hFFFF,0,0, 4'd4);
    vecs[10] = mk(1,16'h0000,16'h0001,1, 1,16'hFFFF,16'h0001,0, 1, 0,1, 1,1,16'h0000,1,0, 4'd5);
    vecs[11] = mk(0,16'h0000,16'h0000,0, 0,16'h0000,16'h0000,0, 1, 0,0, 0,1,16'h0000,1,0, 4'd6);
    vecs[12] = mk(0,16'h0000,16'h0000,0, 1,16'h8000,16'h0001,1, 1, 0,1, 1,1,16'h7FFF,1,1, 4'd6);
    vecs[13] = mk(0,16'h0000,16'h0000,0, 1,16'h1234,16'h4321,0, 1, 0,1, 1,1,16'h5555,0,0, 4'd7);
    vecs[14] = mk(1,16'h0005,16'h0007,1, 0,16'h0000,16'h0000,0, 1, 1,0, 1,0,16'hFFFE,0,0, 4'd8);
    vecs[15] = mk(0,16'h0000,16'h0000,0, 0,16'h0000,16'h0000,0, 1, 0,0, 0,0,16'hFFFE,0,0, 4'd9);
    vecs[16] = mk(0,16'h0000,16'h0000,0, 0,16'h0000,16'h0000,0, 0, 0,0, 0,0,16'hFFFE,0,0, 4'd9);

    #1;
    chk("rst.valid", 32'(res_valid), 32'd0);
    chk("rst.count", 32'(op_count), 32'd0);
    chk("rst.sum",   32'(res_sum), 32'd0);
    chk("rst.ready", {30'd0, req1_ready, req0_ready}, 32'd0);

    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("idle%0d.ready", i), {30'd0, req1_ready, req0_ready}, 32'd0);
      @(posedge clk); #1;
      chk($sformatf("idle%0d.valid", i), 32'(res_valid), 32'd0);
      chk($sformatf("idle%0d.count", i), 32'(op_count), 32'd0);
      $display("[TB] idle cycle %0d valid=%0b count=%0d", i, res_valid, op_count);
    end

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].v0, vecs[i].a0, vecs[i].b0, vecs[i].c0,
            vecs[i].v1, vecs[i].a1, vecs[i].b1, vecs[i].c1, vecs[i].rr);
      @(negedge clk);
      chk($sformatf("v%0d.ready0", i), 32'(req0_ready), 32'(vecs[i].er0));
      chk($sformatf("v%0d.ready1", i), 32'(req1_ready), 32'(vecs[i].er1));
      @(posedge clk); #1;
      chk($sformatf("v%0d.valid", i), 32'(res_valid), 32'(vecs[i].ev));
      chk($sformatf("v%0d.id", i),    32'(res_id),    32'(vecs[i].eid));
      chk($sformatf("v%0d.sum", i),   32'(res_sum),   32'(vecs[i].esum));
      chk($sformatf("v%0d.cout", i),  32'(res_cout),  32'(vecs[i].ec));
      chk($sformatf("v%0d.ovf", i),   32'(res_ovf),   32'(vecs[i].eo));
      chk($sformatf("v%0d.count", i), 32'(op_count),  32'(vecs[i].ecnt));
      $display("[TB] vec %0d valid=%0b id=%0d sum=%04h cout=%0b ovf=%0b count=%0d",
               i, res_valid, res_id, res_sum, res_cout, res_ovf, op_count);
    end

    // Async reset while a result is held under backpressure.
    drive(1, 16'h0001, 16'h0001, 0, 0, 16'h0, 16'h0, 0, 1);
    @(posedge clk); #1;
    chk("hold.valid", 32'(res_valid), 32'd1);
    chk("hold.sum",   32'(res_sum), 32'h0002);
    drive(1, 16'h0001, 16'h0001, 0, 1, 16'h0003, 16'h0001, 0, 0);
    @(posedge clk); #1;
    chk("hold2.sum", 32'(res_sum), 32'h0002);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.valid", 32'(res_valid), 32'd0);
    chk("arst.sum",   32'(res_sum), 32'd0);
    chk("arst.id",    32'(res_id), 32'd0);
    chk("arst.count", 32'(op_count), 32'd0);
    chk("arst.ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    $display("[TB] async reset valid=%0b sum=%04h count=%0d", res_valid, res_sum, op_count);
    #2;
    rst_n = 1'b1;
    res_ready = 1'b1;
    #1;
    chk("post.ready0", 32'(req0_ready), 32'd1);
    chk("post.ready1", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    chk("post.id",  32'(res_id), 32'd0);
    chk("post.sum", 32'(res_sum), 32'h0002);

    // Wrap: 17 accepted-and-consumed ops from reset on a 4-bit counter.
    drive(1, 16'h0010, 16'h0001, 0, 0, 16'h0, 16'h0, 0, 1);
    for (int k = 2; k <= 17; k++) begin
      @(posedge clk); #1;
      if (k == 17) chk("wrap.count16", 32'(op_count), 32'd0);
    end
    drive(0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 1);
    @(posedge clk); #1;
    chk("wrap.count17", 32'(op_count), 32'd1);
    chk("wrap.valid",   32'(res_valid), 32'd0);
    chk("wrap.sum",     32'(res_sum), 32'h0011);
    $display("[TB] wrap count=%0d valid=%0b", op_count, res_valid);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
